// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, reset
// polarity, default NOP encoding and the fetch FSM state encoding.
package if_fetch_pkg;

  localparam int InstrBus     = 32;
  localparam int InstrAddrBus = 32;

  // Reset is active-high
  localparam logic RstEnable = 1'b1;

  // addi x0,x0,0
  localparam logic [InstrBus-1:0] NopInstr = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT     = 3'd2,
    HOLD     = 3'd3,
    DROP     = 3'd4,
    IDLE_ERR = 3'd5
  } fetch_state_t;

  // Sequential PC increment; wraps naturally at 32 bits
  function automatic logic [InstrAddrBus-1:0] pc_incr(input logic [InstrAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pc} holding register used when a fetch response
// arrives while the decode stage is stalled. Clear wins over load.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [InstrBus-1:0]     instr_in,
  input  logic [InstrAddrBus-1:0] pc_in,
  output logic [InstrBus-1:0]     instr,
  output logic [InstrAddrBus-1:0] pc,
  output logic                    full
);

  // Capture a parked response, or drop it on clear
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      instr <= {InstrBus{1'b0}};
      pc    <= {InstrAddrBus{1'b0}};
      full  <= 1'b0;
    end else if (clear) begin
      full  <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      full  <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one request
// outstanding to instruction memory and registers each returned word
// with its PC toward IF_ID. Handles stall (via a skid entry) and
// redirect (flush, discarding any in-flight response).
// Optional build macro IF_MISALIGN_CHK_EN: misaligned redirect targets
// raise exc_misalign_o_IF and park the fetcher until an aligned redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstrAddrBus-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [InstrBus-1:0]     NOP_INSTR = NopInstr
)
(
  input  logic                    clk_i_IF,
  input  logic                    rst_i_IF,
  output logic                    imem_req_o_IF,
  output logic [InstrAddrBus-1:0] imem_addr_o_IF,
  input  logic                    imem_gnt_i_IF,
  input  logic                    imem_rvalid_i_IF,
  input  logic [InstrBus-1:0]     imem_rdata_i_IF,
  input  logic                    stall_i_IF,
  input  logic                    redirect_i_IF,
  input  logic [InstrAddrBus-1:0] redirect_pc_i_IF,
`ifdef IF_MISALIGN_CHK_EN
  output logic                    exc_misalign_o_IF,
`endif
  output logic [InstrBus-1:0]     instr_o_IF,
  output logic [InstrAddrBus-1:0] pc_addr_o_IF,
  output logic                    valid_o_IF
);

  fetch_state_t             state, state_nxt;
  logic [InstrAddrBus-1:0]  pc, pc_nxt;
  logic [InstrBus-1:0]      instr_q, instr_nxt;
  logic [InstrAddrBus-1:0]  pc_addr_q, pc_addr_nxt;
  logic                     valid_q, valid_nxt;
  logic                     skid_load, skid_clear, skid_full;
  logic [InstrBus-1:0]      skid_instr;
  logic [InstrAddrBus-1:0]  skid_pc;
  logic                     outstanding;
  logic [InstrAddrBus-1:0]  redirect_target;

`ifdef IF_MISALIGN_CHK_EN
  logic exc_q, exc_nxt;
  logic misalign;
  assign redirect_target = redirect_pc_i_IF;
  assign misalign        = |redirect_pc_i_IF[1:0];
  assign exc_misalign_o_IF = exc_q;
`else
  // Without the checker the low address bits are simply ignored
  assign redirect_target = redirect_pc_i_IF & 32'hFFFF_FFFC;
`endif

  assign imem_req_o_IF  = (state == REQ);
  assign imem_addr_o_IF = pc;
  assign instr_o_IF     = instr_q;
  assign pc_addr_o_IF   = pc_addr_q;
  assign valid_o_IF     = valid_q;

  if_skid_buf u_skid (
    .clk      (clk_i_IF),
    .rst      (rst_i_IF),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (imem_rdata_i_IF),
    .pc_in    (pc),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .full     (skid_full)
  );

  // Next-state, next-PC and next-output selection; redirect overrides all
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr_q;
    pc_addr_nxt = pc_addr_q;
    valid_nxt   = valid_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    outstanding = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    exc_nxt     = exc_q;
`endif

    // A request is still in flight after this edge if it was granted now
    // or an earlier one has not yet returned.
    case (state)
      REQ:     outstanding = imem_gnt_i_IF;
      WAIT:    outstanding = ~imem_rvalid_i_IF;
      DROP:    outstanding = ~imem_rvalid_i_IF;
      default: outstanding = 1'b0;
    endcase

    if (redirect_i_IF) begin
      pc_nxt     = redirect_target;
      valid_nxt  = 1'b0;
      instr_nxt  = NOP_INSTR;
      skid_clear = 1'b1;
      state_nxt  = outstanding ? DROP : REQ;
`ifdef IF_MISALIGN_CHK_EN
      if (misalign) begin
        state_nxt = IDLE_ERR;
        exc_nxt   = 1'b1;
      end else begin
        exc_nxt   = 1'b0;
      end
`endif
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (imem_gnt_i_IF) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid_i_IF && !stall_i_IF) begin
            instr_nxt   = imem_rdata_i_IF;
            pc_addr_nxt = pc;
            valid_nxt   = 1'b1;
            pc_nxt      = pc_incr(pc);
            state_nxt   = REQ;
          end else if (imem_rvalid_i_IF) begin
            // Decode is stalled: park the word so the bus can move on
            skid_load = 1'b1;
            pc_nxt    = pc_incr(pc);
            state_nxt = HOLD;
          end else begin
            state_nxt = WAIT;
          end
        end
        HOLD: begin
          if (!stall_i_IF) begin
            instr_nxt   = skid_instr;
            pc_addr_nxt = skid_pc;
            valid_nxt   = skid_full;
            skid_clear  = 1'b1;
            state_nxt   = REQ;
          end else begin
            state_nxt   = HOLD;
          end
        end
        DROP: begin
          if (imem_rvalid_i_IF) begin
            state_nxt = REQ;
          end else begin
            state_nxt = DROP;
          end
        end
        IDLE_ERR: state_nxt = IDLE_ERR;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // State, PC and output registers
  always_ff @(posedge clk_i_IF) begin
    if (rst_i_IF == RstEnable) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_addr_q <= {InstrAddrBus{1'b0}};
      valid_q   <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      exc_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_q   <= instr_nxt;
      pc_addr_q <= pc_addr_nxt;
      valid_q   <= valid_nxt;
`ifdef IF_MISALIGN_CHK_EN
      exc_q     <= exc_nxt;
`endif
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage; the producer end of the instr/pc interface that the decode stage consumes through IF_ID.
- Holds the PC, issues one-outstanding requests to instruction memory, and registers each returned word with its PC toward IF_ID.
- Supports hazard stall and branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on instr_o_IF when no valid instruction (addi x0,x0,0)

Ports:
- clk_i_IF  input  1  clock, all logic on rising edge
- rst_i_IF  input  1  synchronous active-high reset (RstEnable = 1)
- imem_req_o_IF  output  1  fetch request valid
- imem_addr_o_IF  output  32  fetch address (word aligned)
- imem_gnt_i_IF  input  1  memory accepts request this cycle
- imem_rvalid_i_IF  input  1  response data valid
- imem_rdata_i_IF  input  32  response instruction word
- stall_i_IF  input  1  IF_ID cannot accept; hold outputs
- redirect_i_IF  input  1  flush and restart at redirect_pc_i_IF
- redirect_pc_i_IF  input  32  redirect target
- instr_o_IF  output  32  instruction to IF_ID
- pc_addr_o_IF  output  32  PC of instr_o_IF
- valid_o_IF  output  1  instr_o_IF/pc_addr_o_IF hold a real instruction

Behaviour:
- Clock and reset: one clock, clk_i_IF. Reset is synchronous and active-high on rst_i_IF.
- Reset values: state=IDLE, pc=RESET_PC, imem_req_o_IF=0, instr_o_IF=NOP_INSTR, pc_addr_o_IF=0, valid_o_IF=0, skid buffer empty, drop flag=0.
- imem_addr_o_IF = pc at all times. imem_req_o_IF = (state==REQ), combinational from state.
- States:
  - IDLE -> REQ on the first cycle after reset deasserts.
  - REQ: request held until gnt. gnt=1 -> WAIT; pc unchanged until the response.
  - WAIT, rvalid=1 and stall=0: outputs <= {rdata, pc, valid=1}; pc <= pc+4; -> REQ.
  - WAIT, rvalid=1 and stall=1: skid <= {rdata, pc}; pc <= pc+4; -> HOLD; outputs unchanged.
  - HOLD, stall=0: outputs <= skid with valid=1; -> REQ.
  - DROP: wait for rvalid, discard the data, -> REQ (pc already holds the redirect target).
- Stall: while stall_i_IF=1, instr/pc/valid outputs hold their values. A REQ in progress may still be granted; the response goes to the skid buffer.
- Output update when leaving WAIT/HOLD with stall=0 while valid_o_IF was already 1: this counts as IF_ID consuming the previous word.
- Redirect has highest priority over stall, rvalid and gnt. On a redirect cycle:
  - pc <= redirect_pc_i_IF; valid_o_IF <= 0; instr_o_IF <= NOP_INSTR; skid cleared.
  - Next state: DROP if a request is outstanding after this edge (state REQ with gnt=1, or WAIT with rvalid=0). Otherwise REQ, including WAIT with rvalid=1, where the response is discarded.
- PC arithmetic: 32-bit wrap; 32'hFFFF_FFFC + 4 = 0.
- Latency: reset release to first valid_o_IF is at least 3 cycles (IDLE, REQ, WAIT with zero-wait memory). Steady state is 1 instruction per 2 cycles.
- Reset mid-operation overrides everything and returns all registers to reset values. The memory is reset by the same signal, so no response is pending afterwards.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined: an extra output exc_misalign_o_IF (1 bit, reset 0). A redirect with redirect_pc_i_IF[1:0]!=0 sets it, sets state=IDLE_ERR (no requests) and holds pc at the raw target. Only a new aligned redirect or reset clears it; an aligned redirect restarts normally.
- Undefined: no extra port; redirect_pc_i_IF[1:0] is forced to 2'b00.

Decomposition:
- Shared package/define file: state encoding (IDLE, REQ, WAIT, HOLD, DROP, IDLE_ERR), NOP_INSTR value, RstEnable, InstrBus/InstrAddrBus widths.
- One natural sub-module, if_skid_buf: a 1-entry {instr, pc} register with load/clear/full.

Test Plan:
- Reset, then zero-wait memory returning pc-tagged words: first valid_o_IF=1 on the 3rd cycle after reset release, with instr=mem[0], pc=0x0. Next valid at pc=0x4, two cycles later.
- gnt delayed 3 cycles: imem_req_o_IF stays 1 with addr=0x8 held, then a normal response follows.
- stall_i_IF=1 for 4 cycles while the word for 0xC returns: outputs hold the 0x8 word. On stall release, pc_addr_o_IF=0xC, valid=1, and the next request is to 0x10.
- Redirect to 0x100 while in WAIT for 0x14: valid_o_IF=0 next cycle. The late rvalid for 0x14 is dropped and never seen at the outputs. The next request address is 0x100.
- Redirect and stall in the same cycle: the flush wins, valid=0, instr=NOP_INSTR, and the fetch restarts at the target.
- With IF_MISALIGN_CHK_EN, redirect to 0x102: exc_misalign_o_IF=1 and no requests. A later redirect to 0x200 clears it and fetches 0x200.
